// File: rtl/register_file.sv
// ============================================================================
//  Module   : register_file
//  Purpose  : 2**ADDR_WIDTH x DATA_WIDTH register file with two combinational
//             read ports, write-through bypass, hardwired-zero entry 0 and a
//             16-bit committed-write counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write_enable,
    input  logic [ADDR_WIDTH-1:0] write_register,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_register_1,
    input  logic [ADDR_WIDTH-1:0] read_register_2,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic [15:0]           write_count
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
    logic [15:0]           r_write_count;
    logic                  w_commit;

    // Enable is evaluated first so an unknown address with the strobe low
    // cannot produce a commit.
    assign w_commit = reg_write_enable && (write_register != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[write_register] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write_count <= '0;
        end else if (w_commit) begin
            r_write_count <= r_write_count + 16'd1;
        end
    end

    assign write_count = r_write_count;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_read_port
            logic [ADDR_WIDTH-1:0] w_addr;
            logic [DATA_WIDTH-1:0] w_data;

            assign w_addr = (p == 0) ? read_register_1 : read_register_2;

            // Reset and address 0 dominate the bypass path.
            always_comb begin
                w_data = '0;
                if (reset || (w_addr == '0)) begin
                    w_data = '0;
                end else if (w_commit && (w_addr == write_register)) begin
                    w_data = write_data;
                end else begin
                    w_data = r_regs[w_addr];
                end
            end
        end
    endgenerate

    assign read_data_1 = g_read_port[0].w_data;
    assign read_data_2 = g_read_port[1].w_data;

endmodule

`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the register and data-port width in bits.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the register address width; depth SHALL be 2**ADDR_WIDTH (32 entries at default).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-high reset.
REQ-005 reg_write_enable  input  1  SHALL be write strobe; 1 = write this cycle.
REQ-006 write_register  input  ADDR_WIDTH  SHALL be the destination address, driven by the write-register selection stage.
REQ-007 write_data  input  DATA_WIDTH  SHALL be the data to be written.
REQ-008 read_register_1  input  ADDR_WIDTH  SHALL be the read port 1 address.
REQ-009 read_register_2  input  ADDR_WIDTH  SHALL be the read port 2 address.
REQ-010 read_data_1  output  DATA_WIDTH  SHALL be the read port 1 data.
REQ-011 read_data_2  output  DATA_WIDTH  SHALL be the read port 2 data.
REQ-012 write_count  output  16  SHALL be the count of committed writes since reset.

Function
REQ-013 Storage SHALL be 2**ADDR_WIDTH entries of DATA_WIDTH bits.
REQ-014 Write: at rising clk edge, if reg_write_enable=1, reset=0 and write_register!=0, the entry at write_register SHALL take write_data; 1-cycle write latency.
REQ-015 Entry 0 SHALL be hardwired zero; writes to address 0 SHALL be discarded.
REQ-016 A write to address 0 SHALL NOT increment write_count.
REQ-017 Reads SHALL be combinational (0-cycle latency) from the addressed entry.
REQ-018 Read of address 0 SHALL return all zeros on both ports.
REQ-019 Bypass: if reg_write_enable=1, write_register!=0 and read_register_N==write_register in the same cycle, read_data_N SHALL equal write_data (write-through), independent per port.
REQ-020 Both ports reading the same address SHALL return identical data.
REQ-021 write_count SHALL increment by 1 on each committed write (REQ-014).
REQ-022 write_count SHALL wrap 0xFFFF -> 0x0000 with no flag and no stall.
REQ-023 Back-to-back writes to the same address SHALL leave the last-written value.
REQ-024 reg_write_enable=0 SHALL leave all entries and write_count unchanged, regardless of write_register/write_data.
REQ-025 X/unknown on write_register while reg_write_enable=0 SHALL NOT corrupt any entry.

Reset
REQ-026 reset=1 SHALL asynchronously clear every entry and write_count to 0, without waiting for clk.
REQ-027 While reset=1, writes SHALL be ignored; read_data_1/2 SHALL read 0 for every address, bypass included.
REQ-028 A write coincident with the clk edge at which reset is asserted SHALL be discarded.
REQ-029 First write SHALL be accepted on the first rising clk edge after reset deasserts.

Verification
REQ-030 Reset: preload r5=0x1234, assert reset mid-cycle -> read_data_1 at addr 5 = 0 before next edge; write_count=0.
REQ-031 Write/read: write r7=0xDEADBEEF, next cycle read_register_1=7, read_register_2=7 -> both ports 0xDEADBEEF; write_count=1.
REQ-032 R0: write r0=0xFFFFFFFF -> read r0 = 0; write_count unchanged.
REQ-033 Bypass: r3=0x11, same cycle write r3=0x22 with read_register_2=3 -> read_data_2=0x22 before edge; read_data_1 at r4 unaffected.
REQ-034 Disabled write: reg_write_enable=0, write_register=9, write_data=0xAA -> r9 keeps prior value; write_count unchanged.
REQ-035 Wrap: 65536 committed writes from reset -> write_count=0x0000; 65537th -> 0x0001.
